// File: rtl/tcb_arb.sv
// TCB multi-manager arbiter: combinational grant, lock under backpressure,
// and one-cycle-delayed read data steered back to the manager that was accepted.

module tcb_arb_lane #(
    parameter int DW = 32
)(
    input  logic          gnt,
    input  logic          rsp,
    input  logic          m_rdy,
    input  logic [DW-1:0] m_rdt,
    output logic          rdy,
    output logic [DW-1:0] rdt
);
    assign rdy = gnt & m_rdy;
    assign rdt = rsp ? m_rdt : '0;
endmodule

module tcb_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = DW/8,
    parameter int MN = 2,
    parameter int RR = 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MN-1:0]          s_vld,
    input  logic [MN-1:0]          s_wen,
    input  logic [MN-1:0][BW-1:0]  s_ben,
    input  logic [MN-1:0][AW-1:0]  s_adr,
    input  logic [MN-1:0][DW-1:0]  s_wdt,
    output logic [MN-1:0][DW-1:0]  s_rdt,
    output logic [MN-1:0]          s_rdy,
    output logic                   m_vld,
    output logic                   m_wen,
    output logic [BW-1:0]          m_ben,
    output logic [AW-1:0]          m_adr,
    output logic [DW-1:0]          m_wdt,
    input  logic [DW-1:0]          m_rdt,
    input  logic                   m_rdy
);
    localparam int PW = (MN > 1) ? $clog2(MN) : 1;

    logic [PW-1:0] ptr, lck_idx, idx;
    logic          lck, hit, xfer;
    logic [MN-1:0] gnt, rsp;
    int            cand;

    // A held request keeps the bus; otherwise search from ptr (RR) or from 0.
    always_comb begin
        idx  = '0;
        hit  = 1'b0;
        cand = 0;
        if (lck && s_vld[lck_idx]) begin
            idx = lck_idx;
            hit = 1'b1;
        end else begin
            for (int k = 0; k < MN; k++) begin
                cand = (RR != 0) ? (int'(ptr) + k) % MN : k;
                if (!hit && s_vld[cand]) begin
                    idx = PW'(cand);
                    hit = 1'b1;
                end
            end
        end
        gnt = '0;
        if (hit) gnt[idx] = 1'b1;
    end

    always_comb begin
        m_wen = 1'b0;
        m_ben = '0;
        m_adr = '0;
        m_wdt = '0;
        for (int i = 0; i < MN; i++) begin
            if (gnt[i]) begin
                m_wen = s_wen[i];
                m_ben = s_ben[i];
                m_adr = s_adr[i];
                m_wdt = s_wdt[i];
            end
        end
    end

    assign m_vld = |(s_vld & gnt);
    assign xfer  = m_vld & m_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            lck     <= 1'b0;
            lck_idx <= '0;
            rsp     <= '0;
        end else begin
            // Lock drops on transfer, or when the holder withdraws its request.
            lck <= m_vld & ~m_rdy;
            if (m_vld & ~m_rdy) lck_idx <= idx;
            if (xfer) begin
                rsp <= gnt;
                ptr <= (RR != 0 && int'(idx) < MN - 1) ? idx + 1'b1 : '0;
            end
        end
    end

    for (genvar i = 0; i < MN; i++) begin : g_lane
        tcb_arb_lane #(.DW(DW)) u_lane (
            .gnt   (gnt[i]),
            .rsp   (rsp[i]),
            .m_rdy (m_rdy),
            .m_rdt (m_rdt),
            .rdy   (s_rdy[i]),
            .rdt   (s_rdt[i])
        );
    end
endmodule

// File: tb/tb_tcb_arb.sv
// Bench for tcb_arb: a 2-port round-robin instance and a 3-port fixed-priority
// instance, directed scenarios followed by random traffic against a reference model.
module tb_tcb_arb;
    localparam int AW = 32, DW = 32, BW = 4;

    logic clk, rst;

    logic [1:0]          a_s_vld, a_s_wen, a_s_rdy;
    logic [1:0][BW-1:0]  a_s_ben;
    logic [1:0][AW-1:0]  a_s_adr;
    logic [1:0][DW-1:0]  a_s_wdt, a_s_rdt;
    logic                a_m_vld, a_m_wen, a_m_rdy;
    logic [BW-1:0]       a_m_ben;
    logic [AW-1:0]       a_m_adr;
    logic [DW-1:0]       a_m_wdt, a_m_rdt;

    logic [2:0]          b_s_vld, b_s_wen, b_s_rdy;
    logic [2:0][BW-1:0]  b_s_ben;
    logic [2:0][AW-1:0]  b_s_adr;
    logic [2:0][DW-1:0]  b_s_wdt, b_s_rdt;
    logic                b_m_vld, b_m_wen, b_m_rdy;
    logic [BW-1:0]       b_m_ben;
    logic [AW-1:0]       b_m_adr;
    logic [DW-1:0]       b_m_wdt, b_m_rdt;

    int checks = 0;
    int errors = 0;

    tcb_arb #(.AW(AW), .DW(DW), .BW(BW), .MN(2), .RR(1)) dut_a (
        .clk(clk), .rst(rst),
        .s_vld(a_s_vld), .s_wen(a_s_wen), .s_ben(a_s_ben), .s_adr(a_s_adr),
        .s_wdt(a_s_wdt), .s_rdt(a_s_rdt), .s_rdy(a_s_rdy),
        .m_vld(a_m_vld), .m_wen(a_m_wen), .m_ben(a_m_ben), .m_adr(a_m_adr),
        .m_wdt(a_m_wdt), .m_rdt(a_m_rdt), .m_rdy(a_m_rdy)
    );

    tcb_arb #(.AW(AW), .DW(DW), .BW(BW), .MN(3), .RR(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_vld(b_s_vld), .s_wen(b_s_wen), .s_ben(b_s_ben), .s_adr(b_s_adr),
        .s_wdt(b_s_wdt), .s_rdt(b_s_rdt), .s_rdy(b_s_rdy),
        .m_vld(b_m_vld), .m_wen(b_m_wen), .m_ben(b_m_ben), .m_adr(b_m_adr),
        .m_wdt(b_m_wdt), .m_rdt(b_m_rdt), .m_rdy(b_m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner: held manager if still requesting, else first requester from start.
    function automatic int pick(input int vld, input int n, input int start, input int hold);
        if (hold >= 0 && ((vld >> hold) & 1) != 0) return hold;
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (((vld >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        a_s_vld = 2'b11; a_s_wen = 2'b00; a_s_ben = '0; a_s_wdt = '0;
        a_s_adr[0] = 32'h1000; a_s_adr[1] = 32'h2000;
        a_m_rdy = 1'b1; a_m_rdt = 32'h1234;
        b_s_vld = 3'b110; b_s_wen = '0; b_s_ben = '0; b_s_adr = '0; b_s_wdt = '0;
        b_m_rdy = 1'b1; b_m_rdt = 32'h5678;
        #1;
        checks++; if (a_m_vld !== 1'b1) begin errors++; $display("FAIL rst_mvld got %b exp 1", a_m_vld); end
        checks++; if (a_s_rdy !== 2'b01) begin errors++; $display("FAIL rst_rdy got %b exp 01", a_s_rdy); end
        checks++; if (a_m_adr !== 32'h1000) begin errors++; $display("FAIL rst_adr got %h exp 1000", a_m_adr); end
        checks++; if (a_s_rdt !== '0) begin errors++; $display("FAIL rst_rdt got %h exp 0", a_s_rdt); end
        checks++; if (b_s_rdy !== 3'b010) begin errors++; $display("FAIL rst_b_rdy got %b exp 010", b_s_rdy); end
        repeat (2) @(negedge clk);
        checks++; if (a_s_rdy !== 2'b01) begin errors++; $display("FAIL rst_hold_rdy got %b exp 01", a_s_rdy); end
        rst = 1'b1; a_s_vld = 2'b00; b_s_vld = 3'b000;
        @(negedge clk);
        a_s_vld = 2'b11; a_m_rdy = 1'b0;
        #1;
        checks++; if (a_m_adr !== 32'h1000) begin errors++; $display("FAIL post_rst_ptr adr %h exp 1000", a_m_adr); end
        checks++; if (a_s_rdt !== '0) begin errors++; $display("FAIL post_rst_rdt got %h exp 0", a_s_rdt); end
        checks++; if (b_s_rdt !== '0) begin errors++; $display("FAIL post_rst_b_rdt got %h exp 0", b_s_rdt); end
        @(negedge clk);
        a_s_vld = 2'b00;
    endtask

    task automatic test_rr();
        logic [1:0] exp;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_s_vld = 2'b11; a_m_rdy = 1'b1;
            #1;
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (a_s_rdy !== exp) begin errors++; $display("FAIL rr_rdy c%0d got %b exp %b", c, a_s_rdy, exp); end
            checks++; if (a_m_adr !== a_s_adr[c % 2]) begin errors++; $display("FAIL rr_adr c%0d got %h exp %h", c, a_m_adr, a_s_adr[c % 2]); end
        end
        @(negedge clk);
        a_s_vld = 2'b00;
    endtask

    task automatic test_fixed();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            b_s_vld = 3'b110; b_m_rdy = 1'b1;
            #1;
            checks++; if (b_s_rdy !== 3'b010) begin errors++; $display("FAIL fp_rdy c%0d got %b exp 010", c, b_s_rdy); end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            b_s_vld = 3'b100;
            #1;
            checks++; if (b_s_rdy !== 3'b100) begin errors++; $display("FAIL fp_p2_rdy c%0d got %b exp 100", c, b_s_rdy); end
        end
        @(negedge clk);
        b_s_vld = 3'b000;
    endtask

    task automatic test_lock();
        a_s_adr[0] = 32'h0044; a_s_adr[1] = 32'h0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a_s_vld = (c == 0) ? 2'b10 : 2'b11; a_m_rdy = 1'b0;
            #1;
            checks++; if (a_m_adr !== 32'h0100 || a_m_vld !== 1'b1)
                begin errors++; $display("FAIL lock_adr c%0d got %h vld %b exp 100", c, a_m_adr, a_m_vld); end
        end
        @(negedge clk);
        a_m_rdy = 1'b1;
        #1;
        checks++; if (a_s_rdy !== 2'b10) begin errors++; $display("FAIL lock_xfer rdy %b exp 10", a_s_rdy); end
        @(negedge clk);
        #1;
        checks++; if (a_s_rdy !== 2'b01 || a_m_adr !== 32'h0044)
            begin errors++; $display("FAIL lock_next rdy %b adr %h exp 01/44", a_s_rdy, a_m_adr); end
        @(negedge clk);
        a_s_vld = 2'b00;
    endtask

    task automatic test_read_routing();
        @(negedge clk);
        a_s_vld = 2'b01; a_s_wen = 2'b00; a_s_adr[0] = 32'h10; a_s_adr[1] = 32'h20;
        a_m_rdy = 1'b1; a_m_rdt = '0;
        #1;
        checks++; if (a_s_rdy !== 2'b01 || a_m_adr !== 32'h10 || a_m_wen !== 1'b0)
            begin errors++; $display("FAIL rd_t0 rdy %b adr %h wen %b", a_s_rdy, a_m_adr, a_m_wen); end
        @(negedge clk);
        a_s_vld = 2'b10; a_m_rdt = 32'hAAAA;
        #1;
        checks++; if (a_s_rdt[0] !== 32'hAAAA || a_s_rdt[1] !== '0)
            begin errors++; $display("FAIL rd_t1 rdt0 %h rdt1 %h exp AAAA/0", a_s_rdt[0], a_s_rdt[1]); end
        checks++; if (a_s_rdy !== 2'b10 || a_m_adr !== 32'h20)
            begin errors++; $display("FAIL rd_t1_req rdy %b adr %h exp 10/20", a_s_rdy, a_m_adr); end
        @(negedge clk);
        a_s_vld = 2'b00; a_m_rdt = 32'hBBBB;
        #1;
        checks++; if (a_s_rdt[1] !== 32'hBBBB || a_s_rdt[0] !== '0)
            begin errors++; $display("FAIL rd_t2 rdt1 %h rdt0 %h exp BBBB/0", a_s_rdt[1], a_s_rdt[0]); end
    endtask

    task automatic test_mid_reset();
        a_s_adr[0] = 32'h0A00; a_s_adr[1] = 32'h0B00;
        @(negedge clk);
        a_s_vld = 2'b01; a_m_rdy = 1'b1;
        @(negedge clk);
        a_s_vld = 2'b11; a_m_rdy = 1'b0;
        #1;
        checks++; if (a_m_adr !== 32'h0B00) begin errors++; $display("FAIL mr_ptr adr %h exp 0B00", a_m_adr); end
        @(negedge clk);
        a_m_rdt = 32'hCAFE;
        #1;
        checks++; if (a_m_adr !== 32'h0B00 || a_s_rdt[0] !== 32'hCAFE)
            begin errors++; $display("FAIL mr_locked adr %h rdt0 %h exp 0B00/CAFE", a_m_adr, a_s_rdt[0]); end
        rst = 1'b0;
        #1;
        checks++; if (a_m_adr !== 32'h0A00 || a_m_vld !== 1'b1)
            begin errors++; $display("FAIL mr_async adr %h vld %b exp 0A00/1", a_m_adr, a_m_vld); end
        checks++; if (a_s_rdt !== '0) begin errors++; $display("FAIL mr_rsp rdt %h exp 0", a_s_rdt); end
        a_m_rdy = 1'b1;
        #1;
        checks++; if (a_s_rdy !== 2'b01) begin errors++; $display("FAIL mr_rdy %b exp 01", a_s_rdy); end
        @(negedge clk);
        rst = 1'b1; a_s_vld = 2'b00; b_s_vld = 3'b000;
    endtask

    task automatic test_random();
        int a_ptr = 0, a_hold = -1, a_rsp = -1, b_hold = -1, b_rsp = -1;
        int wa, wb;
        logic [2:0] er;
        logic [68:0] ef;
        logic [DW-1:0] ed;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) != 0) a_s_vld = 2'($urandom);
            if ($urandom_range(0, 2) != 0) b_s_vld = 3'($urandom);
            a_s_wen = 2'($urandom); b_s_wen = 3'($urandom);
            for (int i = 0; i < 2; i++) begin
                a_s_ben[i] = 4'($urandom); a_s_adr[i] = $urandom; a_s_wdt[i] = $urandom;
            end
            for (int i = 0; i < 3; i++) begin
                b_s_ben[i] = 4'($urandom); b_s_adr[i] = $urandom; b_s_wdt[i] = $urandom;
            end
            a_m_rdy = ($urandom_range(0, 3) != 0); b_m_rdy = ($urandom_range(0, 3) != 0);
            a_m_rdt = $urandom; b_m_rdt = $urandom;
            #1;
            wa = pick(int'(a_s_vld), 2, a_ptr, a_hold);
            er = '0; if (wa >= 0 && a_m_rdy) er[wa] = 1'b1;
            ef = (wa >= 0) ? {a_s_wen[wa], a_s_ben[wa], a_s_adr[wa], a_s_wdt[wa]} : '0;
            checks++; if (a_m_vld !== (wa >= 0)) begin errors++; $display("FAIL rnd_a_vld c%0d got %b exp %b", c, a_m_vld, wa >= 0); end
            checks++; if (a_s_rdy !== er[1:0]) begin errors++; $display("FAIL rnd_a_rdy c%0d got %b exp %b", c, a_s_rdy, er[1:0]); end
            checks++; if ({a_m_wen, a_m_ben, a_m_adr, a_m_wdt} !== ef)
                begin errors++; $display("FAIL rnd_a_fld c%0d got %h exp %h", c, {a_m_wen, a_m_ben, a_m_adr, a_m_wdt}, ef); end
            for (int i = 0; i < 2; i++) begin
                ed = (a_rsp == i) ? a_m_rdt : '0;
                checks++; if (a_s_rdt[i] !== ed) begin errors++; $display("FAIL rnd_a_rdt%0d c%0d got %h exp %h", i, c, a_s_rdt[i], ed); end
            end
            wb = pick(int'(b_s_vld), 3, 0, b_hold);
            er = '0; if (wb >= 0 && b_m_rdy) er[wb] = 1'b1;
            ef = (wb >= 0) ? {b_s_wen[wb], b_s_ben[wb], b_s_adr[wb], b_s_wdt[wb]} : '0;
            checks++; if (b_s_rdy !== er) begin errors++; $display("FAIL rnd_b_rdy c%0d got %b exp %b", c, b_s_rdy, er); end
            checks++; if ({b_m_vld, b_m_wen, b_m_ben, b_m_adr, b_m_wdt} !== {wb >= 0, ef})
                begin errors++; $display("FAIL rnd_b_fld c%0d got %h exp %h", c, {b_m_vld, b_m_wen, b_m_ben, b_m_adr, b_m_wdt}, {wb >= 0, ef}); end
            for (int i = 0; i < 3; i++) begin
                ed = (b_rsp == i) ? b_m_rdt : '0;
                checks++; if (b_s_rdt[i] !== ed) begin errors++; $display("FAIL rnd_b_rdt%0d c%0d got %h exp %h", i, c, b_s_rdt[i], ed); end
            end
            a_hold = (wa >= 0 && !a_m_rdy) ? wa : -1;
            if (wa >= 0 && a_m_rdy) begin a_ptr = (wa + 1) % 2; a_rsp = wa; end
            b_hold = (wb >= 0 && !b_m_rdy) ? wb : -1;
            if (wb >= 0 && b_m_rdy) b_rsp = wb;
        end
    endtask

    initial begin
        test_reset();
        test_rr();
        test_fixed();
        test_lock();
        test_read_routing();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
